// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
//   Data-memory handshake between the RV32I multi-cycle control unit
//   (master) and the data memory (slave).
//
//   busReq    master -> slave  data access request, held for the whole access
//   busWe     master -> slave  1 = store, 0 = load
//   busSize   master -> slave  funct3 of the load/store, valid while busReq=1
//   busReady  slave -> master  access completes this cycle
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if;
  logic       busReq;
  logic       busWe;
  logic [2:0] busSize;
  logic       busReady;

  modport master (
    output busReq,
    output busWe,
    output busSize,
    input  busReady
  );

  modport slave (
    input  busReq,
    input  busWe,
    input  busSize,
    output busReady
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//   Multi-cycle FSM sequencer for the RV32I DataPath. Decodes instrCode and
//   drives every DataPath control input through FETCH/DECODE/EXECUTE/MEM/WB,
//   handshakes loads/stores with data memory and counts retired
//   instructions.
//
//   Optional feature macro: ILLEGAL_TRAP_EN
//     defined   : unknown opcode traps into HALT, illegalInstr port present
//     undefined : unknown opcode executes as a NOP and is retired
//
//   Parameters
//     MEM_WAIT_MAX   cycles spent in MEM waiting for busReady before abort
//
//   Ports
//     clk            system clock, all state on posedge
//     reset          asynchronous, active-low
//     instrCode      current instruction (combinational from PC)
//     PCEn           PC load enable
//     regFileWe      register file write enable
//     aluSrcMuxSel   0 = rs2, 1 = immExt
//     aluControl     ALU op {instr[30]-ish, funct3}
//     RFWDSrcMuxSel  0 alu, 1 mem, 2 imm, 3 PC+imm, 4 PC+4
//     branch/jal/jalr PC-source controls
//     busErr         sticky, set on MEM timeout
//     instRetired    retired-instruction counter (wraps)
//     bus            data-memory handshake (master side)
//     illegalInstr   (ILLEGAL_TRAP_EN only) high while halted
//
//   state   | meaning
//   FETCH   | PC loads next-PC (PCEn)
//   DECODE  | DataPath captures rs1/rs2/immExt
//   EXECUTE | opcode-specific ALU / writeback / PC-source controls
//   MEM     | data access, waits for busReady or timeout
//   WB      | load data written to register file
//   HALT    | illegal opcode trap, exits only through reset
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [31:0]                      instrCode,
  output logic                             PCEn,
  output logic                             regFileWe,
  output logic                             aluSrcMuxSel,
  output logic [3:0]                       aluControl,
  output logic [2:0]                       RFWDSrcMuxSel,
  output logic                             branch,
  output logic                             jal,
  output logic                             jalr,
  output logic                             busErr,
  multicycle_control_unit_if.master        bus,
  output logic [31:0]                      instRetired
`ifdef ILLEGAL_TRAP_EN
  ,output logic                            illegalInstr
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      retired_q, retired_d;
  logic             bus_err_q, bus_err_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_store;
  logic       retire;
  logic       halted;
  logic       bus_req, bus_we;
  logic [2:0] bus_size;
  logic       unused_instr_bits;

  assign opcode   = instrCode[6:0];
  assign funct3   = instrCode[14:12];
  assign is_store = (opcode == OP_S);
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    bus_err_d     = bus_err_q;
    retire        = 1'b0;
    halted        = 1'b0;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    aluControl    = 4'b0000;
    RFWDSrcMuxSel = 3'd0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    bus_req       = 1'b0;
    bus_we        = 1'b0;
    bus_size      = 3'd0;

    case (state_q)
      FETCH: begin
        // FETCH is also the reset state; keep PCEn low while reset is held
        PCEn    = reset;
        state_d = DECODE;
      end

      DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        case (opcode)
          OP_R, OP_I, OP_B, OP_LU, OP_AU, OP_J, OP_JL, OP_L, OP_S:
            state_d = EXECUTE;
          default:
            state_d = HALT;
        endcase
`else
        state_d = EXECUTE;
`endif
      end

      EXECUTE: begin
        retire  = 1'b1;
        state_d = FETCH;
        case (opcode)
          OP_R: begin
            aluControl = {instrCode[30], funct3};
            regFileWe  = 1'b1;
          end
          OP_I: begin
            // instr[30] is an immediate bit except for the shift-right pair
            aluControl   = {(funct3 == 3'b101) ? instrCode[30] : 1'b0, funct3};
            aluSrcMuxSel = 1'b1;
            regFileWe    = 1'b1;
          end
          OP_B: begin
            aluControl = {1'b0, funct3};
            branch     = 1'b1;
          end
          OP_LU: begin
            RFWDSrcMuxSel = 3'd2;
            regFileWe     = 1'b1;
          end
          OP_AU: begin
            RFWDSrcMuxSel = 3'd3;
            regFileWe     = 1'b1;
          end
          OP_J: begin
            jal           = 1'b1;
            RFWDSrcMuxSel = 3'd4;
            regFileWe     = 1'b1;
          end
          OP_JL: begin
            jal           = 1'b1;
            jalr          = 1'b1;
            RFWDSrcMuxSel = 3'd4;
            regFileWe     = 1'b1;
          end
          OP_L, OP_S: begin
            aluControl   = ALU_ADD;
            aluSrcMuxSel = 1'b1;
            retire       = 1'b0;
            wait_cnt_d   = '0;
            state_d      = MEM;
          end
          default: ;
        endcase
      end

      MEM: begin
        // ADD/immExt held so the free-running address register stays stable
        aluControl   = ALU_ADD;
        aluSrcMuxSel = 1'b1;
        bus_req      = 1'b1;
        bus_we       = is_store;
        bus_size     = funct3;
        wait_cnt_d   = wait_cnt_q + 1'b1;
        if (bus.busReady) begin
          if (is_store) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
      end

      WB: begin
        RFWDSrcMuxSel = 3'd1;
        regFileWe     = 1'b1;
        retire        = 1'b1;
        state_d       = FETCH;
      end

      HALT: begin
`ifdef ILLEGAL_TRAP_EN
        halted  = 1'b1;
        state_d = HALT;
`else
        state_d = FETCH;
`endif
      end

      default: state_d = FETCH;
    endcase

    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  assign bus.busReq  = bus_req;
  assign bus.busWe   = bus_we;
  assign bus.busSize = bus_size;
  assign busErr      = bus_err_q;
  assign instRetired = retired_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegalInstr = halted;
`else
  logic unused_halted;
  assign unused_halted = halted;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  localparam int MEM_WAIT_MAX = 16;

  typedef struct packed {
    logic        pcen;
    logic        we;
    logic        sel;
    logic [3:0]  aluc;
    logic [2:0]  rfwd;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        req;
    logic        bwe;
    logic [2:0]  bsize;
    logic        err;
    logic        ill;
    logic [31:0] ret;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] instrCode;
  logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, busErr;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic [31:0] instRetired;
  logic        ill_s;

  multicycle_control_unit_if bus_if();

  multicycle_control_unit #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .instrCode     (instrCode),
    .PCEn          (PCEn),
    .regFileWe     (regFileWe),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .aluControl    (aluControl),
    .RFWDSrcMuxSel (RFWDSrcMuxSel),
    .branch        (branch),
    .jal           (jal),
    .jalr          (jalr),
    .busErr        (busErr),
    .bus           (bus_if.master),
    .instRetired   (instRetired)
`ifdef ILLEGAL_TRAP_EN
    ,.illegalInstr (ill_s)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign ill_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_ret  = 0;
  logic  exp_err  = 1'b0;

  function automatic string fmt(input vec_t v);
    return $sformatf("pcen=%0b we=%0b sel=%0b alu=%b rfwd=%0d br=%0b jal=%0b jalr=%0b req=%0b bwe=%0b bsz=%0d err=%0b ill=%0b ret=%0d",
                     v.pcen, v.we, v.sel, v.aluc, v.rfwd, v.br, v.jal, v.jalr,
                     v.req, v.bwe, v.bsize, v.err, v.ill, v.ret);
  endfunction

  // Monitor: one expected vector per clock, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t  e, a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = {PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel, branch, jal, jalr,
           bus_if.busReq, bus_if.busWe, bus_if.busSize, busErr, ill_s, instRetired};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: actual {%s} required {%s}", nm, fmt(a), fmt(e));
      end
    end
  end

  function automatic vec_t base();
    vec_t e;
    e = '0;
    e.err = exp_err;
    e.ret = exp_ret;
    return e;
  endfunction

  function automatic vec_t mk_exe(input logic we, input logic sel, input logic [3:0] aluc,
                                  input logic [2:0] rfwd, input logic br, input logic j,
                                  input logic jr);
    vec_t e;
    e = base();
    e.we = we; e.sel = sel; e.aluc = aluc; e.rfwd = rfwd;
    e.br = br; e.jal = j; e.jalr = jr;
    return e;
  endfunction

  // Called just after a posedge: apply inputs, queue expectation, advance one clock.
  task automatic cyc(input logic [31:0] instr, input logic rdy, input vec_t e, input string nm);
    instrCode = instr;
    bus_if.busReady = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [31:0] instr, input logic rdy, input string nm);
    vec_t e;
    e = base(); e.pcen = 1'b1;
    cyc(instr, rdy, e, {nm, "_fetch"});
    cyc(instr, rdy, base(), {nm, "_decode"});
  endtask

  task automatic run_simple(input logic [31:0] instr, input vec_t ex, input logic rdy, input string nm);
    fetch_decode(instr, rdy, nm);
    cyc(instr, rdy, ex, {nm, "_exec"});
    exp_ret++;
  endtask

  // ready_at: MEM cycle (1-based) in which busReady is high; 0 = never
  task automatic run_mem(input logic [31:0] instr, input logic st, input int ready_at, input string nm);
    vec_t e;
    logic rdy;
    fetch_decode(instr, 1'b0, nm);
    cyc(instr, 1'b0, mk_exe(0, 1, 4'b0000, 3'd0, 0, 0, 0), {nm, "_exec"});
    for (int k = 1; k <= MEM_WAIT_MAX; k++) begin
      e = base();
      e.sel = 1'b1; e.req = 1'b1; e.bwe = st; e.bsize = instr[14:12];
      rdy = (k == ready_at);
      cyc(instr, rdy, e, $sformatf("%s_mem%0d", nm, k));
      if (rdy) break;
      if (k == MEM_WAIT_MAX) exp_err = 1'b1;
    end
    if (!st && ready_at != 0)
      cyc(instr, 1'b0, mk_exe(1, 0, 4'b0000, 3'd1, 0, 0, 0), {nm, "_wb"});
    exp_ret++;
  endtask

  initial begin
    vec_t e;
    reset = 1'b0;
    instrCode = 32'h0;
    bus_if.busReady = 1'b0;
    @(posedge clk); #1;
    cyc(32'h0, 1'b0, base(), "reset_idle");
    reset = 1'b1;

    // add x3,x1,x2 with busReady asserted throughout (must be ignored)
    run_simple(32'h002081B3, mk_exe(1, 0, 4'b0000, 3'd0, 0, 0, 0), 1'b1, "add");

    // sw timeout
    run_mem(32'h0020A223, 1'b1, 0, "sw_timeout");

    // lw interrupted by reset in MEM
    fetch_decode(32'h0080A283, 1'b0, "lw_rst");
    cyc(32'h0080A283, 1'b0, mk_exe(0, 1, 4'b0000, 3'd0, 0, 0, 0), "lw_rst_exec");
    e = base(); e.sel = 1'b1; e.req = 1'b1; e.bsize = 3'b010;
    cyc(32'h0080A283, 1'b0, e, "lw_rst_mem1");
    cyc(32'h0080A283, 1'b0, e, "lw_rst_mem2");
    reset = 1'b0;
    exp_ret = 0;
    exp_err = 1'b0;
    cyc(32'h0080A283, 1'b0, base(), "reset_mid_mem");
    reset = 1'b1;

    run_mem(32'h0080A283, 1'b0, 4, "lw_wait3");
    run_mem(32'h0020A223, 1'b1, 1, "sw_ok");
    run_simple(32'h402081B3, mk_exe(1, 0, 4'b1000, 3'd0, 0, 0, 0), 1'b0, "sub");
    run_simple(32'hFFF00093, mk_exe(1, 1, 4'b0000, 3'd0, 0, 0, 0), 1'b0, "addi_neg");
    run_simple(32'h4020D193, mk_exe(1, 1, 4'b1101, 3'd0, 0, 0, 0), 1'b0, "srai");
    run_simple(32'h00208463, mk_exe(0, 0, 4'b0000, 3'd0, 1, 0, 0), 1'b0, "beq");
    run_simple(32'h00209463, mk_exe(0, 0, 4'b0001, 3'd0, 1, 0, 0), 1'b0, "bne");
    run_simple(32'h123452B7, mk_exe(1, 0, 4'b0000, 3'd2, 0, 0, 0), 1'b0, "lui");
    run_simple(32'h00001297, mk_exe(1, 0, 4'b0000, 3'd3, 0, 0, 0), 1'b0, "auipc");
    run_simple(32'h010000EF, mk_exe(1, 0, 4'b0000, 3'd4, 0, 1, 0), 1'b0, "jal");
    run_simple(32'h000100E7, mk_exe(1, 0, 4'b0000, 3'd4, 0, 1, 1), 1'b0, "jalr");

`ifdef ILLEGAL_TRAP_EN
    fetch_decode(32'h0000007F, 1'b0, "illegal");
    e = base(); e.ill = 1'b1;
    for (int k = 0; k < 4; k++)
      cyc(32'h0000007F, 1'b0, e, $sformatf("illegal_halt%0d", k));
`else
    run_simple(32'h0000007F, mk_exe(0, 0, 4'b0000, 3'd0, 0, 0, 0), 1'b0, "illegal_nop");
    e = base(); e.pcen = 1'b1;
    cyc(32'h002081B3, 1'b0, e, "after_nop_fetch");
`endif

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: actual %0d pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
